// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : button_conditioner
//  Purpose  : Per-channel synchroniser, debouncer, edge detector and
//             optional auto-repeat for raw push-buttons and switches.
//  Revision : 1.0  initial release
// ============================================================================

module button_conditioner #(
  parameter int unsigned N_CH            = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD   = 10_000_000,
  parameter int unsigned CNT_W           = $clog2(
    ((DEBOUNCE_CYCLES > REPEAT_DELAY)
       ? ((DEBOUNCE_CYCLES > REPEAT_PERIOD) ? DEBOUNCE_CYCLES : REPEAT_PERIOD)
       : ((REPEAT_DELAY    > REPEAT_PERIOD) ? REPEAT_DELAY    : REPEAT_PERIOD)) + 1)
) (
  input  logic            clk_100mhz,
  input  logic            reset,
  input  logic [N_CH-1:0] btn_in,
  input  logic [N_CH-1:0] repeat_en,
  output logic [N_CH-1:0] clean_out,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] held_out
);

  localparam logic [1:0] c_st_idle      = 2'd0;
  localparam logic [1:0] c_st_pressed   = 2'd1;
  localparam logic [1:0] c_st_repeating = 2'd2;

  localparam logic [CNT_W-1:0] c_deb_last = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_dly_last = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] c_per_last = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  genvar ch;
  for (ch = 0; ch < int'(N_CH); ch++) begin : g_ch
    logic             s1_q, s2_q;
    logic             clean_q, clean_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic [CNT_W-1:0] rcnt_q, rcnt_d;
    logic [1:0]       state_q, state_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             held_q, held_d;
    logic             w_accept, w_rise, w_fall, w_rep_fire;

    // Acceptance fires on the edge where s2 has disagreed for DEBOUNCE_CYCLES edges
    assign w_accept = (s2_q != clean_q) && (dcnt_q == c_deb_last);
    assign w_rise   = w_accept &  s2_q;
    assign w_fall   = w_accept & ~s2_q;

    always_comb begin
      clean_d = clean_q;
      dcnt_d  = dcnt_q;
      if (s2_q == clean_q) begin
        dcnt_d = '0;
      end else if (w_accept) begin
        clean_d = s2_q;
        dcnt_d  = '0;
      end else begin
        dcnt_d = dcnt_q + c_cnt_one;
      end
    end

    always_ff @(posedge clk_100mhz) begin
      if (reset) begin
        s1_q      <= 1'b0;
        s2_q      <= 1'b0;
        clean_q   <= 1'b0;
        dcnt_q    <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        held_q    <= 1'b0;
      end else begin
        s1_q      <= btn_in[ch];
        s2_q      <= s1_q;
        clean_q   <= clean_d;
        dcnt_q    <= dcnt_d;
        press_q   <= press_d;
        release_q <= release_d;
        held_q    <= held_d;
      end
    end

    always_ff @(posedge clk_100mhz) begin
      if (reset) begin
        state_q <= c_st_idle;
        rcnt_q  <= '0;
      end else begin
        state_q <= state_d;
        rcnt_q  <= rcnt_d;
      end
    end

    always_comb begin
      state_d    = state_q;
      rcnt_d     = rcnt_q;
      w_rep_fire = 1'b0;
      case (state_q)
        c_st_idle: begin
          rcnt_d = '0;
          if (w_rise) state_d = c_st_pressed;
        end
        c_st_pressed: begin
          if (!repeat_en[ch]) begin
            rcnt_d = '0;
          end else if (rcnt_q == c_dly_last) begin
            w_rep_fire = 1'b1;
            rcnt_d     = '0;
            state_d    = c_st_repeating;
          end else begin
            rcnt_d = rcnt_q + c_cnt_one;
          end
        end
        c_st_repeating: begin
          if (!repeat_en[ch]) begin
            rcnt_d  = '0;
            state_d = c_st_pressed;
          end else if (rcnt_q == c_per_last) begin
            w_rep_fire = 1'b1;
            rcnt_d     = '0;
          end else begin
            rcnt_d = rcnt_q + c_cnt_one;
          end
        end
        default: begin
          rcnt_d  = '0;
          state_d = c_st_idle;
        end
      endcase
      // A release always wins over a repeat falling due on the same edge
      if (w_fall) begin
        state_d = c_st_idle;
        rcnt_d  = '0;
      end
    end

    always_comb begin
      press_d   = w_rise | (w_rep_fire & ~w_fall);
      release_d = w_fall;
      held_d    = (state_q == c_st_repeating);
    end

    assign clean_out[ch]     = clean_q;
    assign press_pulse[ch]   = press_q;
    assign release_pulse[ch] = release_q;
    assign held_out[ch]      = held_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_button_conditioner
//  Purpose  : Directed self-checking bench for button_conditioner against a
//             timestamp-based behavioural model.
//  Revision : 1.0  initial release
// ============================================================================

module tb_button_conditioner;

  localparam int N  = 3;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn;
  logic [N-1:0] ren;
  logic [N-1:0] clean_o, press_o, rel_o, held_o;

  always #5 clk = ~clk;

  button_conditioner #(
    .N_CH(N), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk_100mhz   (clk),
    .reset        (rst),
    .btn_in       (btn),
    .repeat_en    (ren),
    .clean_out    (clean_o),
    .press_pulse  (press_o),
    .release_pulse(rel_o),
    .held_out     (held_o)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  bit m_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: acceptance when s2 has held a value differing from clean for D
  // edges (timestamp of last s2 change); repeats counted as runs of enabled
  // cycles since the last press pulse.
  logic [N-1:0] m_s1, m_s2, m_clean, m_pressed, m_rep, m_p, m_r, m_h;
  int           m_ts2 [N];
  int           m_run [N];

  initial forever begin
    bit acc, h_new;
    @(posedge clk);
    cyc++;
    for (int c = 0; c < N; c++) begin
      if (rst) begin
        m_s1[c] = 1'b0; m_s2[c] = 1'b0; m_clean[c] = 1'b0; m_ts2[c] = cyc;
        m_pressed[c] = 1'b0; m_rep[c] = 1'b0; m_run[c] = 0;
        m_p[c] = 1'b0; m_r[c] = 1'b0; m_h[c] = 1'b0;
      end else begin
        h_new = m_rep[c];
        acc   = (m_s2[c] != m_clean[c]) && (cyc - m_ts2[c] == D);
        m_p[c] = 1'b0;
        m_r[c] = 1'b0;
        if (acc) begin
          m_clean[c]   = m_s2[c];
          m_pressed[c] = m_s2[c];
          m_rep[c]     = 1'b0;
          m_run[c]     = 0;
          if (m_s2[c]) m_p[c] = 1'b1;
          else         m_r[c] = 1'b1;
        end else if (m_pressed[c]) begin
          if (ren[c]) begin
            m_run[c]++;
            if (m_run[c] == (m_rep[c] ? RP : RD)) begin
              m_p[c]   = 1'b1;
              m_run[c] = 0;
              m_rep[c] = 1'b1;
            end
          end else begin
            m_run[c] = 0;
            m_rep[c] = 1'b0;
          end
        end
        if (m_s1[c] != m_s2[c]) m_ts2[c] = cyc;
        m_s2[c] = m_s1[c];
        m_s1[c] = btn[c];
        m_h[c]  = h_new;
      end
    end
    if (rst) m_valid = 1'b1;
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      check("clean_out",     32'(clean_o), 32'(m_clean));
      check("press_pulse",   32'(press_o), 32'(m_p));
      check("release_pulse", 32'(rel_o),   32'(m_r));
      check("held_out",      32'(held_o),  32'(m_h));
      check("press_release_overlap", 32'(press_o & rel_o), 32'd0);
    end
  end

  // Pulse timestamps for the hand-computed literal expectations
  int p_t [N][64];
  int r_t [N][64];
  int p_n [N];
  int r_n [N];
  int h_rise [N];

  initial forever begin
    @(posedge clk);
    #1;
    for (int c = 0; c < N; c++) begin
      if (press_o[c] === 1'b1) begin
        if (p_n[c] < 64) p_t[c][p_n[c]] = cyc;
        p_n[c]++;
      end
      if (rel_o[c] === 1'b1) begin
        if (r_n[c] < 64) r_t[c][r_n[c]] = cyc;
        r_n[c]++;
      end
      if (held_o[c] === 1'b1 && h_rise[c] < 0) h_rise[c] = cyc;
    end
  end

  task automatic clr();
    for (int c = 0; c < N; c++) begin
      p_n[c] = 0; r_n[c] = 0; h_rise[c] = -1;
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int s, c0, c1;
    rst = 1'b1; btn = 3'b111; ren = 3'b000;
    clr();

    // Reset with all buttons held, then fresh press after release of reset
    cycles(3);
    check("reset_clean", 32'(clean_o), 32'd0);
    check("reset_press", 32'(press_o), 32'd0);
    check("reset_held",  32'(held_o),  32'd0);
    c0 = cyc; s = c0 + 1; rst = 1'b0;
    cycles(8);
    check("post_reset_clean", 32'(clean_o), 32'h7);
    for (int c = 0; c < N; c++) begin
      check("post_reset_press_count", p_n[c], 1);
      check("post_reset_press_lat",   p_t[c][0] - s, 5);
    end
    btn = 3'b000;
    cycles(8);

    // Clean press/release on ch0
    clr(); c0 = cyc; btn = 3'b001;
    cycles(20);
    c1 = cyc; btn = 3'b000;
    cycles(8);
    check("ch0_press_count", p_n[0], 1);
    check("ch0_press_lat",   p_t[0][0] - (c0 + 1), 5);
    check("ch0_rel_count",   r_n[0], 1);
    check("ch0_rel_lat",     r_t[0][0] - (c1 + 1), 5);
    check("ch0_crosstalk",   p_n[1] + p_n[2] + r_n[1] + r_n[2], 0);

    // Bounce on ch1
    clr();
    btn = 3'b010; cycles(2); btn = 3'b000; cycles(2);
    btn = 3'b010; cycles(2); btn = 3'b000; cycles(2);
    c0 = cyc; btn = 3'b010;
    cycles(12);
    check("bounce_press_count", p_n[1], 1);
    check("bounce_press_lat",   p_t[1][0] - (c0 + 1), 5);
    btn = 3'b000;
    cycles(8);

    // Auto-repeat on ch2, release suppresses the repeat due on the same edge
    clr(); ren = 3'b100; c0 = cyc; s = c0 + 1; btn = 3'b100;
    cycles(40);
    btn = 3'b000;
    cycles(10);
    check("rep_press_count", p_n[2], 7);
    check("rep_first",       p_t[2][0] - s, 5);
    check("rep_delay",       p_t[2][1] - p_t[2][0], RD);
    check("rep_period_a",    p_t[2][2] - p_t[2][1], RP);
    check("rep_period_b",    p_t[2][6] - p_t[2][5], RP);
    check("rep_held_rise",   h_rise[2] - s, 16);
    check("rep_rel_count",   r_n[2], 1);
    check("rep_rel_lat",     r_t[2][0] - s, 45);

    // Drop repeat_en for 7 cycles while repeating
    clr(); ren = 3'b100; c0 = cyc; s = c0 + 1; btn = 3'b100;
    cycles(22);
    ren = 3'b000;
    cycles(7);
    c1 = cyc; ren = 3'b100;
    cycles(16);
    btn = 3'b000;
    cycles(12);
    ren = 3'b000;
    check("mode_press_count", p_n[2], 6);
    check("mode_before_drop", p_t[2][2] - s, 20);
    check("mode_after_raise", p_t[2][3] - c1, 10);

    // Independence: ch0 plain, ch1 repeating; ch0 release meets ch1 repeat
    clr(); ren = 3'b010; c0 = cyc; s = c0 + 1; btn = 3'b011;
    cycles(20);
    btn = 3'b010;
    cycles(10);
    btn = 3'b000;
    cycles(10);
    ren = 3'b000;
    check("ind_ch0_press", p_n[0], 1);
    check("ind_ch0_rel",   r_t[0][0] - s, 25);
    check("ind_ch1_press", p_n[1], 5);
    check("ind_ch1_coinc", p_t[1][3] - s, 25);
    check("ind_ch1_rel",   r_t[1][0] - s, 35);
    check("ind_ch2_quiet", p_n[2] + r_n[2], 0);

    // Reset while repeating with the button still held
    clr(); ren = 3'b100; c0 = cyc; s = c0 + 1; btn = 3'b100;
    cycles(20);
    rst = 1'b1;
    cycles(2);
    c1 = cyc; rst = 1'b0;
    cycles(10);
    check("midrst_press_count", p_n[2], 3);
    check("midrst_repress_lat", p_t[2][2] - (c1 + 1), 5);
    btn = 3'b000; ren = 3'b000;
    cycles(10);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
